reg_dest_pipe: RTL and testbench
================================

// Module: reg_dest_pipe
// PURPOSE
//  Parametrised successor to the 2:1 write-register mux. Selects the destination register
//  (rt, rd or link register, or no write) and carries (addr, en) through a DEPTH-stage
//  shift pipeline to the register-file write port. Each cycle it compares two decode-stage
//  source registers against every in-flight destination to flag RAW hazards and pick a
//  forwarding stage.
// PARAMETERS
//  REG_W     5   register address width
//  DEPTH     3   in-flight stages (EX, MEM, WB); legal range 2..8
//  LINK_REG  31  destination used when sel = 2'b10 (jal/jalr)
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  sel       in   2          00 = in0 (rt), 01 = in1 (rd), 10 = LINK_REG, 11 = no write
//  in0       in   REG_W      rt field
//  in1       in   REG_W      rd field
//  valid_in  in   1          an instruction enters stage 0 this cycle
//  wen_in    in   1          the instruction writes a register
//  stall     in   1          freeze all stages
//  flush     in   1          kill stages 0..DEPTH-2
//  src_a     in   REG_W      decode source A (rs)
//  src_b     in   REG_W      decode source B (rt)
//  dest_out  out  REG_W      combinational selected destination (sel=11 -> 0)
//  hit_a     out  DEPTH      per-stage match on src_a; bit i = stage i
//  hit_b     out  DEPTH      per-stage match on src_b
//  hazard_a  out  1          |hit_a
//  hazard_b  out  1          |hit_b
//  fwd_a     out  $clog2(DEPTH+1)  lowest (youngest) i with hit_a[i]; DEPTH if none
//  fwd_b     out  $clog2(DEPTH+1)  same for src_b
//  wb_addr   out  REG_W      stage DEPTH-1 address
//  wb_en     out  1          register-file write strobe
// BEHAVIOUR
//  - Stage i holds {addr[REG_W-1:0], en}. On reset, every stage = {0,0}, so wb_en = 0,
//    wb_addr = 0, all hit bits = 0, hazard_* = 0 and fwd_* = DEPTH. dest_out follows inputs.
//  - Capture: en0 = valid_in & wen_in & (sel != 2'b11) & (dest_out != 0). Register 0 never
//    creates an entry. addr0 = dest_out.
//  - Normal cycle (stall = 0, flush = 0): stage0 <= capture, stage i <= stage i-1. Latency
//    from the capture edge to wb_en is DEPTH-1 cycles. Each entry asserts wb_en for exactly
//    one cycle.
//  - stall = 1: every stage holds its value and inputs are ignored. wb_en = stage[D-1].en &
//    ~stall, so a held write fires once, in the first cycle after the stall ends.
//  - flush = 1, stall = 0: stages 0..DEPTH-2 <= {0,0} and capture is discarded. Stage DEPTH-1
//    <= old stage DEPTH-2, so the resolving instruction still retires.
//  - flush = 1, stall = 1: stages 0..DEPTH-2 <= {0,0} and stage DEPTH-1 holds. Flush wins
//    for the younger stages.
//  - Hit: hit_x[i] = stage[i].en & (stage[i].addr == src_x) & (src_x != 0). This is
//    combinational from registered state only, with no path from sel, in0 or in1.
//  - Multiple stages matching: all hit bits set, and fwd_x is the lowest index (youngest
//    producer).
//  - Reset asserted mid-operation clears all stages immediately and asynchronously. No write
//    strobe is produced while rst_n = 0.
//  - All comparisons are unsigned and REG_W wide, with no truncation.
// TESTING
//  - Reset: rst_n = 0 with stages loaded -> wb_en = 0, hazard_a/b = 0 and fwd_a/b = DEPTH,
//    all asynchronously, before the next clk edge.
//  - Select: in0 = 5'd29, in1 = 5'd25. sel = 00/01/10/11 -> dest_out = 29/25/31/0.
//  - Pipeline: valid_in = 1, wen_in = 1, sel = 01, in1 = 7 for one cycle -> wb_en = 1 with
//    wb_addr = 7 exactly 2 cycles after capture (DEPTH = 3), then 0.
//  - r0 and forwarding: writes to 0, then 4, then 4 on consecutive cycles. With src_a = 4:
//    hit_a = 3'b011 and fwd_a = 0. With src_a = 0: hazard_a = 0.
//  - Stall: wb pending on addr 9 when stall is held for 3 cycles -> wb_en = 0 throughout the
//    stall; wb_en = 1 exactly once after release.
//  - Flush: stages hold addrs 3/5/6 (stage 0/1/2) when flush pulses -> next cycle wb_addr = 5
//    with wb_en = 1, and stages 0..1 are empty. With stall also high: wb_addr stays 6 and
//    stages 0..1 are empty.

Source files
------------

// File: rtl/reg_dest_pipe.sv
// reg_dest_pipe
//   Selects the destination register of the instruction entering the pipeline
//   (rt, rd, link register or none), carries {addr, en} through a DEPTH-stage
//   shift pipeline to the register-file write port, and compares two decode
//   source registers against every in-flight destination to flag RAW hazards
//   and choose the youngest forwarding stage.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   sel               00 = in0 (rt), 01 = in1 (rd), 10 = LINK_REG, 11 = no write
//   in0, in1          rt / rd fields
//   valid_in, wen_in  instruction enters stage 0 / instruction writes a register
//   stall             freeze all stages
//   flush             kill stages 0..DEPTH-2
//   src_a, src_b      decode-stage source registers
//   dest_out          combinational selected destination (0 when sel = 11)
//   hit_a, hit_b      per-stage source match, bit i = stage i
//   hazard_a/b        any stage matches
//   fwd_a/b           youngest matching stage, DEPTH when none
//   wb_addr, wb_en    register-file write port (oldest stage)
module reg_dest_pipe #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 sel,
  input  logic [REG_W-1:0]           in0,
  input  logic [REG_W-1:0]           in1,
  input  logic                       valid_in,
  input  logic                       wen_in,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [REG_W-1:0]           src_a,
  input  logic [REG_W-1:0]           src_b,
  output logic [REG_W-1:0]           dest_out,
  output logic [DEPTH-1:0]           hit_a,
  output logic [DEPTH-1:0]           hit_b,
  output logic                       hazard_a,
  output logic                       hazard_b,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b,
  output logic [REG_W-1:0]           wb_addr,
  output logic                       wb_en
);

  localparam int unsigned FW = $clog2(DEPTH + 1);

  // One in-flight destination entry
  typedef struct packed {
    logic [REG_W-1:0] addr;
    logic             en;
  } stage_t;

  stage_t stage_q [DEPTH];
  stage_t cap;

  // Destination select
  always_comb begin
    dest_out = '0;
    unique case (sel)
      2'b00:   dest_out = in0;
      2'b01:   dest_out = in1;
      2'b10:   dest_out = REG_W'(LINK_REG);
      default: dest_out = '0;
    endcase
  end

  // Stage-0 capture; register 0 never creates a live entry
  always_comb begin
    cap.addr = dest_out;
    cap.en   = valid_in & wen_in & (sel != 2'b11) & (dest_out != '0);
  end

  // Shift pipeline; flush clears the younger stages but lets the oldest
  // one advance (or hold under stall) so the resolving instruction retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) stage_q[i] <= '0;
      if (!stall) stage_q[DEPTH-1] <= stage_q[DEPTH-2];
    end else if (!stall) begin
      stage_q[0] <= cap;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Write port; a held write is suppressed while stalled so it fires once
  assign wb_addr = stage_q[DEPTH-1].addr;
  assign wb_en   = stage_q[DEPTH-1].en & ~stall;

  // Per-stage source compares, from registered state only
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_hit
    assign hit_a[g] = stage_q[g].en & (stage_q[g].addr == src_a) & (|src_a);
    assign hit_b[g] = stage_q[g].en & (stage_q[g].addr == src_b) & (|src_b);
  end

  assign hazard_a = |hit_a;
  assign hazard_b = |hit_b;

  // Youngest producer wins: scan from oldest to youngest so the lowest index sticks
  always_comb begin
    fwd_a = FW'(DEPTH);
    fwd_b = FW'(DEPTH);
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (hit_a[i]) fwd_a = FW'(i);
      if (hit_b[i]) fwd_b = FW'(i);
    end
  end

endmodule

// File: tb/tb_reg_dest_pipe.sv
// tb_reg_dest_pipe
//   Directed scenarios plus randomized traffic for reg_dest_pipe, checked
//   against a queue-based model of the in-flight destinations.
module tb_reg_dest_pipe;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LINK_REG = 31;
  localparam int unsigned FW       = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       sel;
  logic [REG_W-1:0] in0, in1, src_a, src_b;
  logic             valid_in, wen_in, stall, flush;
  logic [REG_W-1:0] dest_out, wb_addr;
  logic [DEPTH-1:0] hit_a, hit_b;
  logic             hazard_a, hazard_b, wb_en;
  logic [FW-1:0]    fwd_a, fwd_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: index 0 = youngest, DEPTH-1 = oldest
  logic [REG_W-1:0] m_addr[$];
  logic             m_en[$];

  always #5 clk = ~clk;

  reg_dest_pipe #(.REG_W(REG_W), .DEPTH(DEPTH), .LINK_REG(LINK_REG)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in0(in0), .in1(in1),
    .valid_in(valid_in), .wen_in(wen_in), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .dest_out(dest_out),
    .hit_a(hit_a), .hit_b(hit_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_addr(wb_addr), .wb_en(wb_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [REG_W-1:0] ref_dest(input logic [1:0] s,
                                                input logic [REG_W-1:0] a0,
                                                input logic [REG_W-1:0] a1);
    case (s)
      2'd0:    return a0;
      2'd1:    return a1;
      2'd2:    return REG_W'(LINK_REG);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DEPTH-1:0] ref_hits(input logic [REG_W-1:0] src);
    logic [DEPTH-1:0] h = '0;
    for (int i = 0; i < int'(DEPTH); i++)
      h[i] = m_en[i] && (m_addr[i] == src) && (src != 0);
    return h;
  endfunction

  function automatic logic [FW-1:0] ref_fwd(input logic [DEPTH-1:0] h);
    for (int i = 0; i < int'(DEPTH); i++)
      if (h[i]) return FW'(i);
    return FW'(DEPTH);
  endfunction

  task automatic model_clear();
    m_addr.delete();
    m_en.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_addr.push_back('0);
      m_en.push_back(1'b0);
    end
  endtask

  // Apply the pipeline rules for one rising edge using the current inputs
  task automatic model_step();
    logic [REG_W-1:0] d, keep_a;
    logic             ce, keep_e;
    if (!rst_n) begin
      model_clear();
      return;
    end
    d  = ref_dest(sel, in0, in1);
    ce = valid_in && wen_in && (sel != 2'b11) && (d != 0);
    if (flush) begin
      keep_a = stall ? m_addr[DEPTH-1] : m_addr[DEPTH-2];
      keep_e = stall ? m_en[DEPTH-1]   : m_en[DEPTH-2];
      model_clear();
      m_addr[DEPTH-1] = keep_a;
      m_en[DEPTH-1]   = keep_e;
    end else if (!stall) begin
      m_addr.push_front(d);
      m_en.push_front(ce);
      void'(m_addr.pop_back());
      void'(m_en.pop_back());
    end
  endtask

  task automatic check_all();
    logic [DEPTH-1:0] ha, hb;
    ha = ref_hits(src_a);
    hb = ref_hits(src_b);
    check("dest_out", 32'(dest_out), 32'(ref_dest(sel, in0, in1)));
    check("hit_a",    32'(hit_a),    32'(ha));
    check("hit_b",    32'(hit_b),    32'(hb));
    check("hazard_a", 32'(hazard_a), 32'(|ha));
    check("hazard_b", 32'(hazard_b), 32'(|hb));
    check("fwd_a",    32'(fwd_a),    32'(ref_fwd(ha)));
    check("fwd_b",    32'(fwd_b),    32'(ref_fwd(hb)));
    check("wb_addr",  32'(wb_addr),  32'(m_addr[DEPTH-1]));
    check("wb_en",    32'(wb_en),    32'(m_en[DEPTH-1] && !stall && rst_n));
  endtask

  task automatic drive(input logic [1:0] s, input logic [REG_W-1:0] a0, input logic [REG_W-1:0] a1,
                       input logic v, input logic w, input logic st, input logic fl,
                       input logic [REG_W-1:0] sa, input logic [REG_W-1:0] sb);
    sel = s; in0 = a0; in1 = a1; valid_in = v; wen_in = w;
    stall = st; flush = fl; src_a = sa; src_b = sb;
  endtask

  task automatic idle(input logic [REG_W-1:0] sa, input logic [REG_W-1:0] sb);
    drive(2'b11, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, sa, sb);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Settle, compare against the model, then clock
  task automatic cyc();
    #2;
    check_all();
    tick();
  endtask

  task automatic write_rd(input logic [REG_W-1:0] r);
    drive(2'b01, 5'd0, r, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    cyc();
  endtask

  initial begin
    int sel_exp[4];
    sel_exp = '{29, 25, 31, 0};
    model_clear();
    rst_n = 1'b0;
    idle('0, '0);
    #2;
    check("reset_wb_en", 32'(wb_en), 32'd0);
    check("reset_fwd_a", 32'(fwd_a), 32'(DEPTH));
    check_all();
    tick();
    rst_n = 1'b1;

    // Destination select
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 5'd29, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      #2;
      check("select", 32'(dest_out), 32'(sel_exp[s]));
      check_all();
      tick();
    end

    // Single write: wb_en exactly two cycles after capture
    write_rd(5'd7);
    for (int k = 0; k < 4; k++) begin
      idle('0, '0);
      #2;
      check("pipe_wb_en", 32'(wb_en), 32'(k == 2));
      if (k == 2) check("pipe_wb_addr", 32'(wb_addr), 32'd7);
      check_all();
      tick();
    end

    // r0 never creates an entry; youngest producer is forwarded
    drive(2'b00, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    cyc();
    drive(2'b00, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    cyc();
    write_rd(5'd4);
    idle(5'd4, 5'd0);
    #2;
    check("r0_hit_a", 32'(hit_a), 32'b011);
    check("r0_fwd_a", 32'(fwd_a), 32'd0);
    src_a = 5'd0;
    #1;
    check("r0_hazard_a", 32'(hazard_a), 32'd0);
    check_all();
    tick();
    repeat (3) begin idle('0, '0); cyc(); end

    // Stall holds a pending write on r9, then it fires once
    write_rd(5'd9);
    idle('0, '0); cyc();
    idle('0, '0); cyc();
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 5'd0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 5'd13);
      #2;
      check("stall_wb_en", 32'(wb_en), 32'd0);
      check_all();
      tick();
    end
    idle('0, '0);
    #2;
    check("stall_release_en", 32'(wb_en), 32'd1);
    check("stall_release_addr", 32'(wb_addr), 32'd9);
    check_all();
    tick();
    idle('0, '0);
    #2;
    check("stall_once", 32'(wb_en), 32'd0);
    check_all();
    tick();

    // Flush with 3/5/6 in stages 0/1/2
    write_rd(5'd6); write_rd(5'd5); write_rd(5'd3);
    drive(2'b01, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
    cyc();
    idle(5'd3, 5'd5);
    #2;
    check("flush_wb_addr", 32'(wb_addr), 32'd5);
    check("flush_wb_en", 32'(wb_en), 32'd1);
    check("flush_hit_a", 32'(hit_a), 32'd0);
    check("flush_hit_b", 32'(hit_b), 32'b100);
    check_all();
    tick();

    // Flush together with stall
    write_rd(5'd6); write_rd(5'd5); write_rd(5'd3);
    drive(2'b01, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
    cyc();
    idle(5'd3, 5'd5);
    #2;
    check("flstall_wb_addr", 32'(wb_addr), 32'd6);
    check("flstall_wb_en", 32'(wb_en), 32'd1);
    check("flstall_hit_a", 32'(hit_a), 32'd0);
    check("flstall_hit_b", 32'(hit_b), 32'd0);
    check_all();
    tick();

    // Asynchronous reset mid-operation
    write_rd(5'd4); write_rd(5'd5); write_rd(5'd6);
    idle(5'd5, 5'd6);
    #2;
    check("pre_reset_hazard", 32'(hazard_a), 32'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_wb_en", 32'(wb_en), 32'd0);
    check("async_hazard_a", 32'(hazard_a), 32'd0);
    check("async_hazard_b", 32'(hazard_b), 32'd0);
    check("async_fwd_a", 32'(fwd_a), 32'(DEPTH));
    check("async_fwd_b", 32'(fwd_b), 32'(DEPTH));
    check_all();
    tick();
    drive(2'b01, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7);
    cyc();
    rst_n = 1'b1;

    // Randomized traffic over a small register range to provoke matches
    for (int n = 0; n < 1500; n++) begin
      drive(2'($urandom_range(0, 3)),
            REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 8),
            REG_W'($urandom_range(0, 7)), REG_W'(($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7)));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
